// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths and constants for the synchronous FIFO controller.
// ptr_t / cnt_t describe the default 256-entry configuration; the width
// functions give the same widths for any power-of-two depth.
package sync_fifo_pkg;

  // Registered RAM read latency; the output skid buffer holds one word per
  // cycle of latency plus the word being presented.
  localparam int RD_LATENCY    = 1;
  localparam int SKID_DEPTH    = RD_LATENCY + 1;
  localparam int DEFAULT_DEPTH = 256;

  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEFAULT_DEPTH):0]   cnt_t;

  // Pointer width for a given depth (addresses modulo depth).
  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so a full FIFO is representable.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: producer/consumer stream bundle of the synchronous FIFO.
// The count signal exists only when SYNC_FIFO_COUNT_EN is defined.
interface sync_fifo_ctrl_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  full;
  logic                  empty;
`ifdef SYNC_FIFO_COUNT_EN
  logic [cnt_bits(FIFO_DEPTH)-1:0] count;
`endif

  // Producer/consumer view (drives payload and handshakes into the FIFO).
  modport master (
    output in_data, in_valid, out_ready,
`ifdef SYNC_FIFO_COUNT_EN
    input  count,
`endif
    input  in_ready, out_data, out_valid, full, empty
  );

  // FIFO view.
  modport slave (
    input  in_data, in_valid, out_ready,
`ifdef SYNC_FIFO_COUNT_EN
    output count,
`endif
    output in_ready, out_data, out_valid, full, empty
  );

endinterface

// File: rtl/dual_port_RAM.sv
// dual_port_RAM: two-port RAM, writes on either port, registered read on port 1.
// Contents are not reset.
module dual_port_RAM #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    din0,
  input  logic                     wr_en0,
  input  logic [$clog2(DEPTH)-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    din1,
  input  logic                     wr_en1,
  output logic [DATA_WIDTH-1:0]    dout1
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array writes from both ports and one-cycle registered read on port 1.
  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem[addr0] <= din0;
    end
    if (wr_en1) begin
      mem[addr1] <= din1;
    end
    dout1 <= mem[addr1];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: synchronous FIFO around dual_port_RAM with first-word-fall-through
// output through a 2-entry skid buffer. Port 0 writes, port 1 reads.
// Optional macro SYNC_FIFO_COUNT_EN exposes the registered occupancy on bus.count.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave bus
);

  localparam int            PW      = ptr_bits(FIFO_DEPTH);
  localparam int            CW      = cnt_bits(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [2:0]    SKID_C  = 3'(SKID_DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         occ, occ_next;
  logic [CW-1:0]         ram_cnt, ram_cnt_next;
  logic                  accept_en, full_flag, empty_flag;
  logic                  in_flight;
  logic                  head_valid, head_valid_next, spare_valid, spare_valid_next;
  logic [DATA_WIDTH-1:0] head_data, head_data_next, spare_data, spare_data_next;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  push, pop, issue;
  logic [2:0]            stage_used, stage_limit;

  assign push = bus.in_valid & accept_en;
  assign pop  = head_valid & bus.out_ready;

  // A read may be issued only if its word will find a free skid slot; a pop
  // this cycle frees one, which keeps the stream bubble-free.
  assign stage_used  = {2'b00, head_valid} + {2'b00, spare_valid} + {2'b00, in_flight};
  assign stage_limit = SKID_C + {2'b00, pop};
  assign issue       = (ram_cnt != ZERO_C) && (stage_used < stage_limit);

  dual_port_RAM #(DATA_WIDTH, FIFO_DEPTH) ram (
    .clk    (clk),
    .addr0  (wr_ptr),
    .din0   (bus.in_data),
    .wr_en0 (push),
    .addr1  (rd_ptr),
    .din1   ({DATA_WIDTH{1'b0}}),
    .wr_en1 (1'b0),
    .dout1  (ram_rdata)
  );

  // Occupancy and committed-unread RAM entry bookkeeping.
  always_comb begin
    occ_next     = occ;
    ram_cnt_next = ram_cnt;
    if (push && !pop) begin
      occ_next = occ + ONE_C;
    end else if (!push && pop) begin
      occ_next = occ - ONE_C;
    end else begin
      occ_next = occ;
    end
    if (push && !issue) begin
      ram_cnt_next = ram_cnt + ONE_C;
    end else if (!push && issue) begin
      ram_cnt_next = ram_cnt - ONE_C;
    end else begin
      ram_cnt_next = ram_cnt;
    end
  end

  // Skid buffer: a pop promotes the spare, then returning RAM data fills the
  // first free slot (head before spare).
  always_comb begin
    head_valid_next  = head_valid;
    head_data_next   = head_data;
    spare_valid_next = spare_valid;
    spare_data_next  = spare_data;
    if (pop) begin
      head_valid_next  = spare_valid;
      spare_valid_next = 1'b0;
      if (spare_valid) begin
        head_data_next = spare_data;
      end else begin
        head_data_next = head_data;
      end
    end else begin
      head_valid_next  = head_valid;
      spare_valid_next = spare_valid;
    end
    if (in_flight) begin
      if (!head_valid_next) begin
        head_valid_next = 1'b1;
        head_data_next  = ram_rdata;
      end else begin
        spare_valid_next = 1'b1;
        spare_data_next  = ram_rdata;
      end
    end else begin
      spare_data_next = spare_data;
    end
  end

  // State registers; reset drops all contents and ignores any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= {PW{1'b0}};
      rd_ptr      <= {PW{1'b0}};
      occ         <= ZERO_C;
      ram_cnt     <= ZERO_C;
      accept_en   <= 1'b1;
      full_flag   <= 1'b0;
      empty_flag  <= 1'b1;
      in_flight   <= 1'b0;
      head_valid  <= 1'b0;
      head_data   <= {DATA_WIDTH{1'b0}};
      spare_valid <= 1'b0;
      spare_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PONE_C;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PONE_C;
      end
      occ         <= occ_next;
      ram_cnt     <= ram_cnt_next;
      accept_en   <= (occ_next != DEPTH_C);
      full_flag   <= (occ_next == DEPTH_C);
      empty_flag  <= (occ_next == ZERO_C);
      in_flight   <= issue;
      head_valid  <= head_valid_next;
      head_data   <= head_data_next;
      spare_valid <= spare_valid_next;
      spare_data  <= spare_data_next;
    end
  end

  assign bus.in_ready  = accept_en;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.full      = full_flag;
  assign bus.empty     = empty_flag;
`ifdef SYNC_FIFO_COUNT_EN
  assign bus.count     = occ;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: self-checking bench for sync_fifo_ctrl with an in-order
// scoreboard fed on accepted pushes and checked on every pop.
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total     = 0;
  int bad       = 0;
  int pop_total = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare each popped word with the oldest accepted push.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        total     = total + 1;
        pop_total = pop_total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL sb_order: got %02h required no output (nothing pending)", bus.out_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.out_data !== exp_d) begin
            bad = bad + 1;
            $display("FAIL sb_order: got %02h required %02h", bus.out_data, exp_d);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      total = total + 1;
      if ({bus.empty, bus.full, bus.out_valid, bus.in_ready} !== 4'b1001 || bus.out_data !== 8'h00) begin
        bad = bad + 1;
        $display("FAIL reset_idle cyc%0d: got e,f,v,r=%b data=%02h required 1001 data=00",
                 i, {bus.empty, bus.full, bus.out_valid, bus.in_ready}, bus.out_data);
      end
`ifdef SYNC_FIFO_COUNT_EN
      total = total + 1;
      if (bus.count !== 9'd0) begin
        bad = bad + 1;
        $display("FAIL reset_count: got %0d required 0", bus.count);
      end
`endif
    end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    logic exp_v, exp_e;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        bus.in_valid = 1'b1;
        bus.in_data = vals[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      exp_v = (k >= 2) && (k <= 4);
      exp_e = (k == 5);
      total = total + 1;
      if (bus.out_valid !== exp_v || bus.empty !== exp_e) begin
        bad = bad + 1;
        $display("FAIL basic_flags edge N+%0d: got valid=%b empty=%b required valid=%b empty=%b",
                 k, bus.out_valid, bus.empty, exp_v, exp_e);
      end
      if (exp_v) begin
        total = total + 1;
        if (bus.out_data !== vals[k-2]) begin
          bad = bad + 1;
          $display("FAIL basic_data edge N+%0d: got %02h required %02h", k, bus.out_data, vals[k-2]);
        end
      end
    end
  endtask

  task automatic fill_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom_range(0, 255));
      tick();
    end
  endtask

  task automatic drain(input int expect_pops, input string name);
    int start;
    start = pop_total;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (pop_total - start >= expect_pops && bus.empty && !bus.out_valid) break;
      tick();
    end
    total = total + 1;
    if (pop_total - start !== expect_pops || bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s_drain: got pops=%0d empty=%b valid=%b pending=%0d required pops=%0d empty=1 valid=0 pending=0",
               name, pop_total - start, bus.empty, bus.out_valid, exp_q.size(), expect_pops);
    end
  endtask

  task automatic test_fill();
    fill_full();
    total = total + 1;
    if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL fill_full: got full=%b in_ready=%b required full=1 in_ready=0", bus.full, bus.in_ready);
    end
`ifdef SYNC_FIFO_COUNT_EN
    total = total + 1;
    if (bus.count !== 9'd256) begin
      bad = bad + 1;
      $display("FAIL fill_count: got %0d required 256", bus.count);
    end
`endif
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    repeat (3) tick();
    total = total + 1;
    if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL fill_overflow: got full=%b in_ready=%b valid=%b required 1 0 1",
               bus.full, bus.in_ready, bus.out_valid);
    end
    drain(DEPTH, "fill");
  endtask

  task automatic test_full_push_pop();
    fill_full();
    bus.in_valid = 1'b1;
    bus.in_data = 8'hC3;
    bus.out_ready = 1'b1;
    total = total + 1;
    if (bus.in_ready !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL fullpp_ready_before: got %b required 0", bus.in_ready);
    end
    tick();
    total = total + 1;
    if (bus.full !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL fullpp_after_pop: got full=%b in_ready=%b valid=%b required 0 1 1",
               bus.full, bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b0;
    tick();
    total = total + 1;
    if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL fullpp_repush: got full=%b in_ready=%b required 1 0", bus.full, bus.in_ready);
    end
`ifdef SYNC_FIFO_COUNT_EN
    total = total + 1;
    if (bus.count !== 9'd256) begin
      bad = bad + 1;
      $display("FAIL fullpp_count: got %0d required 256", bus.count);
    end
`endif
    drain(DEPTH, "fullpp");
  endtask

  task automatic test_wrap();
    int pushed;
    int start;
    logic acc;
    pushed = 0;
    start = pop_total;
    bus.in_valid = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (!bus.in_valid && pushed < 600 && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'($urandom_range(0, 255));
      end
      bus.out_ready = ($urandom_range(0, 1) == 1);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        pushed = pushed + 1;
        bus.in_valid = 1'b0;
      end
      if (pushed == 600 && pop_total - start == 600) break;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    total = total + 1;
    if (pushed != 600 || pop_total - start != 600 || exp_q.size() != 0 || bus.empty !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL wrap_totals: got pushed=%0d popped=%0d pending=%0d empty=%b required 600 600 0 1",
               pushed, pop_total - start, exp_q.size(), bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    int found;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i + 1);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    total = total + 1;
    if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.full !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL rstmid_flags: got empty=%b valid=%b in_ready=%b full=%b required 1 0 1 0",
               bus.empty, bus.out_valid, bus.in_ready, bus.full);
    end
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.out_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    total = total + 1;
    if (found == 0) begin
      bad = bad + 1;
      $display("FAIL rstmid_timeout: got no out_valid in 10 cycles required A5");
    end else if (bus.out_data !== 8'hA5) begin
      bad = bad + 1;
      $display("FAIL rstmid_first: got %02h required a5", bus.out_data);
    end
    repeat (3) tick();
    total = total + 1;
    if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL rstmid_end: got empty=%b valid=%b required 1 0", bus.empty, bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous FIFO built around the team's `dual_port_RAM`. It sits directly upstream of the RAM and drives its address and write-enable inputs: port 0 is the write port and port 1 is the read port. It converts the RAM's 1-cycle registered read into first-word-fall-through valid/ready streams on both sides. It is the storage and flow-control stage used between producer and consumer pipelines in the same clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload width in bits.
- `FIFO_DEPTH`, 256, total entries; a power of 2, ≥4.

Ports:
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  write payload.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO accepts `in_data` this cycle.
- `out_data`  out  DATA_WIDTH  head-of-queue payload.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `full`  out  1  occupancy == FIFO_DEPTH.
- `empty`  out  1  occupancy == 0.
- `count`  out  $clog2(FIFO_DEPTH)+1  occupancy; present only with `SYNC_FIFO_COUNT_EN`.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = !full`. A producer must hold `in_data` and `in_valid` until accepted. The consumer must not rely on `out_data` changing while `out_valid && !out_ready`; it stays stable.
- Occupancy counts every accepted entry not yet popped. This includes entries in RAM, entries with a RAM read in flight, and entries in the output stage. Total never exceeds FIFO_DEPTH.
- Write pointer `wr_ptr` (log2 FIFO_DEPTH bits) drives RAM port 0 on each push: `addr0 = wr_ptr`, `din0 = in_data`, `wr_en0 = 1`. `wr_ptr` then increments and wraps from FIFO_DEPTH-1 to 0.
- Read pointer `rd_ptr` drives `addr1`; `wr_en1` is tied to 0.
  - A RAM read is issued in any cycle where at least one committed RAM entry is unread and the output stage has room for the returning word, counting the read already in flight.
  - `rd_ptr` increments and wraps on each issued read.
- Output stage is a 2-entry skid buffer (head and spare). Returning RAM data goes to the head if the head is free, otherwise to the spare. On a pop, the spare moves to the head.
- An entry is never read in the same cycle it is written, so RAM read/write address collision cannot occur.
- Simultaneous push and pop when full: pop completes; `in_ready` stays 0 that cycle because it is registered from `full`; the push is accepted the next cycle.
- Simultaneous push and pop at occupancy 1 with the head valid: both complete and occupancy stays 1.
- Pointer arithmetic is modulo FIFO_DEPTH. Occupancy arithmetic is $clog2(FIFO_DEPTH)+1 bits and never wraps.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `full`=0, `empty`=1, `count`=0. Both pointers, the skid buffer and the in-flight flag clear.
- Reset asserted mid-operation discards all contents at the next edge. The RAM array is not cleared; stale words are never presented.
- `full`, `empty` and `count` are registered and reflect pushes and pops at the edge where they occur.
- First-word latency: a push at edge N into an empty FIFO gives read issued in cycle N..N+1, data at edge N+2, and `out_valid`=1 from edge N+2.
- `empty` falls at edge N; `out_valid` rises later at edge N+2.
- Sustained throughput: 1 push and 1 pop per cycle with no bubbles once the output stage is primed.
- `out_ready` held 0 for any duration, then released, loses and duplicates no data.

## Configuration
- `SYNC_FIFO_COUNT_EN` defined: the `count` port exists and carries registered occupancy.
- Not defined: the `count` port is absent and the internal occupancy counter is still used for `full` and `empty`.
- All other behaviour is identical in both builds.

## Structure
- Package `sync_fifo_pkg`:
  - `ptr_t` (log2 FIFO_DEPTH-bit pointer) and `cnt_t` (occupancy) width helpers.
  - Localparam `RD_LATENCY = 1`, which sizes the skid buffer (RD_LATENCY+1 entries).
- Sub-module: one instance of `dual_port_RAM #(DATA_WIDTH, FIFO_DEPTH)`. Control logic stays flat in `sync_fifo_ctrl`.

## Test plan
- Reset then idle: `empty`=1, `full`=0, `out_valid`=0, `in_ready`=1, `count`=0 for 10 cycles.
- Push 0x11, 0x22, 0x33 on consecutive edges with `out_ready`=1: `out_valid` rises 2 edges after the first push; outputs 0x11, 0x22, 0x33 on consecutive cycles; `empty`=1 afterwards.
- Fill 256 random bytes with `out_ready`=0: `full`=1 and `in_ready`=0 after the 256th push; a 257th `in_valid` is not accepted. Drain then returns the identical sequence.
- Wrap-around: 600 pushes and pops with random `in_valid`/`out_ready` (50%): output order matches a scoreboard and no loss or duplication occurs.
- When full, assert `out_ready` and `in_valid` together: one pop, no push that cycle, push accepted next cycle, `count` returns to 256.
- `rst` pulsed mid-stream at occupancy 40: next cycle `empty`=1 and `out_valid`=0; a following push of 0xA5 emerges as the first output.
